// File: rtl/lab3_pkg.sv
// Shared constants for the lab 3 response checker: FSM encoding and vector sizing.
package lab3_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned VEC_W       = 3;
    localparam int unsigned STATE_W     = 2;
    localparam int unsigned CNT_W       = 4;

    localparam logic [STATE_W-1:0] S_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] S_DRIVE  = 2'd1;
    localparam logic [STATE_W-1:0] S_SAMPLE = 2'd2;
    localparam logic [STATE_W-1:0] S_DONE   = 2'd3;

    // Expected F for one vector index taken from the packed truth table.
    function automatic logic expected_bit(input logic [NUM_VECTORS-1:0] table_i,
                                          input logic [VEC_W-1:0]       idx_i);
        return table_i[idx_i];
    endfunction

endpackage

// File: rtl/lab3_settle_counter.sv
// Settle-window counter: counts up while enabled, clears on request, flags the terminal value.
module lab3_settle_counter
    import lab3_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: clear has priority over increment.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {CNT_W{1'b0}};
        end else if (en) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign at_term = (count_q == term);

endmodule

// File: rtl/lab3_response_checker.sv
// Exhaustive 3-input truth-table checker: walks X/Y/Z through all vectors, samples F
// after a settle window and accumulates a registered pass/fail verdict.
module lab3_response_checker
    import lab3_pkg::*;
#(
    parameter logic [7:0]  EXPECTED = 8'b1001_0110,
    parameter int unsigned SETTLE   = 3
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       F,
    output logic       X,
    output logic       Y,
    output logic       Z,
    output logic       busy,
    output logic       check_valid,
    output logic       check_fail,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [7:0] fail_vec
);

    localparam logic [CNT_W-1:0] SETTLE_TERM = CNT_W'(SETTLE - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(NUM_VECTORS - 1);

    logic [STATE_W-1:0]     state_q, state_d;
    logic [VEC_W-1:0]       idx_q, idx_d;
    logic [VEC_W-1:0]       xyz_q, xyz_d;
    logic                   busy_q, busy_d;
    logic                   check_valid_q, check_valid_d;
    logic                   check_fail_q, check_fail_d;
    logic                   done_q, done_d;
    logic                   pass_q, pass_d;
    logic [3:0]             err_q, err_d;
    logic [NUM_VECTORS-1:0] fail_vec_q, fail_vec_d;
    logic                   mismatch_s;
    logic                   cnt_clr_s;
    logic                   cnt_term_s;

    // The counter only runs in DRIVE and is zero on entry to every DRIVE window.
    assign cnt_clr_s  = (state_q != S_DRIVE) || cnt_term_s;
    assign mismatch_s = F ^ expected_bit(EXPECTED, idx_q);

    lab3_settle_counter u_settle (
        .clk     (clk),
        .rst     (rst),
        .clr     (cnt_clr_s),
        .en      (1'b1),
        .term    (SETTLE_TERM),
        .at_term (cnt_term_s)
    );

    // FSM next-state, vector sequencing and result accumulation.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        xyz_d         = xyz_q;
        busy_d        = busy_q;
        check_valid_d = 1'b0;
        check_fail_d  = 1'b0;
        done_d        = done_q;
        pass_d        = pass_q;
        err_d         = err_q;
        fail_vec_d    = fail_vec_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d    = S_DRIVE;
                    idx_d      = {VEC_W{1'b0}};
                    xyz_d      = {VEC_W{1'b0}};
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = 4'd0;
                    fail_vec_d = {NUM_VECTORS{1'b0}};
                end else begin
                    xyz_d = {VEC_W{1'b0}};
                end
            end
            S_DRIVE: begin
                xyz_d = idx_q;
                if (cnt_term_s) begin
                    state_d = S_SAMPLE;
                end else begin
                    state_d = S_DRIVE;
                end
            end
            S_SAMPLE: begin
                check_valid_d = 1'b1;
                check_fail_d  = mismatch_s;
                if (mismatch_s) begin
                    err_d      = err_q + 4'd1;
                    fail_vec_d = fail_vec_q | (8'd1 << idx_q);
                end else begin
                    err_d      = err_q;
                    fail_vec_d = fail_vec_q;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    xyz_d   = {VEC_W{1'b0}};
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 4'd0);
                end else begin
                    state_d = S_DRIVE;
                    idx_d   = idx_q + 3'd1;
                    xyz_d   = idx_q + 3'd1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                idx_d      = {VEC_W{1'b0}};
                xyz_d      = {VEC_W{1'b0}};
                busy_d     = 1'b0;
                done_d     = 1'b0;
                pass_d     = 1'b0;
                err_d      = 4'd0;
                fail_vec_d = {NUM_VECTORS{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            idx_q         <= {VEC_W{1'b0}};
            xyz_q         <= {VEC_W{1'b0}};
            busy_q        <= 1'b0;
            check_valid_q <= 1'b0;
            check_fail_q  <= 1'b0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            err_q         <= 4'd0;
            fail_vec_q    <= {NUM_VECTORS{1'b0}};
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            xyz_q         <= xyz_d;
            busy_q        <= busy_d;
            check_valid_q <= check_valid_d;
            check_fail_q  <= check_fail_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            err_q         <= err_d;
            fail_vec_q    <= fail_vec_d;
        end
    end

    assign X           = xyz_q[2];
    assign Y           = xyz_q[1];
    assign Z           = xyz_q[0];
    assign busy        = busy_q;
    assign check_valid = check_valid_q;
    assign check_fail  = check_fail_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign err_count   = err_q;
    assign fail_vec    = fail_vec_q;

endmodule

// File: tb/tb_lab3_response_checker.sv
// Scoreboard bench: instance A (SETTLE=3) against a configurable behavioural DUT, instance B (SETTLE=1) against XOR.
module tb_lab3_response_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    int         mode = 0;

    logic       f_a, x_a, y_a, z_a, busy_a, cv_a, cf_a, done_a, pass_a;
    logic [3:0] err_a;
    logic [7:0] fv_a;
    logic       f_b, x_b, y_b, z_b, busy_b, cv_b, cf_b, done_b, pass_b;
    logic [3:0] err_b;
    logic [7:0] fv_b;

    int n_checks = 0;
    int n_pass   = 0;
    bit qa[$];
    bit qb[$];

    always #5 clk = ~clk;

    // Behavioural DUT models: 0 = XOR, 1 = stuck-at-0, 2 = XOR inverted at vector 101.
    always_comb begin
        case (mode)
            1:       f_a = 1'b0;
            2:       f_a = (x_a ^ y_a ^ z_a) ^ ({x_a, y_a, z_a} == 3'b101);
            default: f_a = x_a ^ y_a ^ z_a;
        endcase
    end
    assign f_b = x_b ^ y_b ^ z_b;

    lab3_response_checker #(.EXPECTED(8'b1001_0110), .SETTLE(3)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .F(f_a),
        .X(x_a), .Y(y_a), .Z(z_a), .busy(busy_a),
        .check_valid(cv_a), .check_fail(cf_a), .done(done_a), .pass(pass_a),
        .err_count(err_a), .fail_vec(fv_a)
    );

    lab3_response_checker #(.EXPECTED(8'b1001_0110), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .F(f_b),
        .X(x_b), .Y(y_b), .Z(z_b), .busy(busy_b),
        .check_valid(cv_b), .check_fail(cf_b), .done(done_b), .pass(pass_b),
        .err_count(err_b), .fail_vec(fv_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor A: every compare pulse pops one expected check_fail.
    always @(negedge clk) begin
        if (cv_a === 1'b1) begin
            if (qa.size() == 0) chk("unexpected_check_a", 32'd1, 32'd0);
            else chk("check_fail_a", {31'd0, cf_a}, {31'd0, qa.pop_front()});
        end
    end

    // Monitor B: same for the SETTLE=1 instance.
    always @(negedge clk) begin
        if (cv_b === 1'b1) begin
            if (qb.size() == 0) chk("unexpected_check_b", 32'd1, 32'd0);
            else chk("check_fail_b", {31'd0, cf_b}, {31'd0, qb.pop_front()});
        end
    end

    function automatic logic [31:0] outs(input bit b);
        if (b) return {12'd0, x_b, y_b, z_b, busy_b, cv_b, cf_b, done_b, pass_b, err_b, fv_b};
        else   return {12'd0, x_a, y_a, z_a, busy_a, cv_a, cf_a, done_a, pass_a, err_a, fv_a};
    endfunction

    // One run: push expected compares, start, walk edges; mid_cyc re-pulses start, rst_cyc resets.
    task automatic run(input string nm, input bit b, input logic [7:0] mask, input int lat,
                       input int mid_cyc, input int rst_cyc, input int n_push,
                       input bit exp_pass, input logic [3:0] exp_err);
        logic [31:0] o;
        int sp;
        bit got_done;
        sp = lat / 8;
        got_done = 1'b0;
        for (int i = 0; i < n_push; i++) begin
            if (b) qb.push_back(mask[i]); else qa.push_back(mask[i]);
        end
        @(negedge clk);
        if (b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        o = outs(b);
        // busy, done, pass, err_count, fail_vec right after the accepting edge
        chk({nm, "_accept"}, {o[16], o[13], o[12], o[11:0]}, {1'b1, 1'b0, 1'b0, 12'd0});
        for (int cyc = 1; cyc <= 200; cyc++) begin
            if (cyc == mid_cyc) begin
                if (b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0; start_b = 1'b0;
            end
            if (cyc == rst_cyc) rst = 1'b1;
            @(posedge clk); #1;
            start_a = 1'b0; start_b = 1'b0;
            if (cyc == rst_cyc) begin
                rst = 1'b0;
                chk({nm, "_reset_outputs"}, outs(b), 32'd0);
                @(negedge clk);
                chk({nm, "_queue_drained"}, qa.size() + qb.size(), 32'd0);
                return;
            end
            o = outs(b);
            if (o[13]) begin
                got_done = 1'b1;
                chk({nm, "_latency"}, cyc, lat);
                chk({nm, "_pass"}, {31'd0, o[12]}, {31'd0, exp_pass});
                chk({nm, "_err_count"}, {28'd0, o[11:8]}, {28'd0, exp_err});
                chk({nm, "_fail_vec"}, {24'd0, o[7:0]}, {24'd0, mask});
                chk({nm, "_xyz_busy_done"}, {28'd0, o[19:16]}, 32'd0);
                break;
            end
            chk({nm, "_xyz_walk"}, {29'd0, o[19:17]}, cyc / sp);
        end
        if (!got_done) chk({nm, "_done_timeout"}, 32'd0, 32'd1);
        @(posedge clk); #1;
        chk({nm, "_queue_drained"}, qa.size() + qb.size(), 32'd0);
        chk({nm, "_done_holds"}, {31'd0, outs(b)}, {31'd0, 1'b1} & 32'd0 | {31'd0, outs(b)} & ~32'h2000 | 32'h2000);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", outs(1'b0), 32'd0);
        chk("reset_b", outs(1'b1), 32'd0);
        // rst and start together: reset wins
        start_a = 1'b1;
        @(posedge clk); #1;
        chk("rst_beats_start", outs(1'b0), 32'd0);
        start_a = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_quiet", outs(1'b0), 32'd0);

        mode = 0; run("xor",       1'b0, 8'h00, 32, 0,  0,  8, 1'b1, 4'd0);
        mode = 1; run("stuck0",    1'b0, 8'h96, 32, 0,  0,  8, 1'b0, 4'd4);
        mode = 2; run("fault101",  1'b0, 8'h20, 32, 0,  0,  8, 1'b0, 4'd1);
        mode = 0; run("busystart", 1'b0, 8'h00, 32, 14, 0,  8, 1'b1, 4'd0);
        mode = 1; run("midreset",  1'b0, 8'h96, 32, 0,  20, 4, 1'b0, 4'd0);
        mode = 0; run("afterrst",  1'b0, 8'h00, 32, 0,  0,  8, 1'b1, 4'd0);
        run("settle1", 1'b1, 8'h00, 16, 0, 0, 8, 1'b1, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
